sparce_skip_ctrl: RTL and testbench

- Sequences SparCE skips; sits beside fetch and is driven from the pipeline side of the SparCE interface.
- Tracks which architectural registers currently hold zero (SRF) from writeback traffic.
- Holds a small SASA table that software programs through a two-write config sequence.
- When fetch PC hits a table entry whose condition register is zero, issues a redirect (`sparce_target`, `skipping`) and holds it until fetch acknowledges.

---
 rtl/sparce_skip_ctrl.sv | 138 +++++++++++++
 tb/tb_sparce_skip_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sparce_skip_ctrl.sv
// SparCE skip sequencer: tracks zero-valued registers from writeback, holds the
// software-programmed SASA table and raises a held fetch redirect on a table hit.
module sparce_skip_ctrl #(
  parameter int unsigned SASA_ENTRIES = 4,
  parameter logic [31:0] SASA_BASE    = 32'h0000_2000,
  parameter int unsigned HOLDOFF      = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        sasa_wen,
  input  logic [31:0] sasa_addr,
  input  logic [31:0] sasa_data,
  input  logic        redirect_ack,
  output logic [31:0] sparce_target,
  output logic        skipping
);

  localparam int unsigned IDX_W       = (SASA_ENTRIES > 1) ? $clog2(SASA_ENTRIES) : 1;
  localparam logic [31:0] STAGE_ADDR  = SASA_BASE;
  localparam logic [31:0] COMMIT_ADDR = SASA_BASE + 32'd4;

  typedef enum logic {CFG_IDLE, CFG_STAGED} cfg_state_t;
  typedef enum logic [1:0] {SK_IDLE, SK_REDIRECT, SK_HOLDOFF} skip_state_t;

  cfg_state_t              r_cfg_state;
  skip_state_t             r_skip_state;
  logic [31:0]             r_srf;
  logic [31:0]             r_stage_pc;
  logic [3:0]              r_hold;
  logic [SASA_ENTRIES-1:0] r_valid;
  logic [31:0]             r_epc [SASA_ENTRIES];
  logic [4:0]              r_rs  [SASA_ENTRIES];
  logic [7:0]              r_len [SASA_ENTRIES];

  logic [SASA_ENTRIES-1:0] w_cond_zero;
  logic [SASA_ENTRIES-1:0] w_hit;
  logic                    w_any_hit;
  logic [IDX_W-1:0]        w_hit_idx;
  logic [31:0]             w_hit_target;
  logic [IDX_W-1:0]        w_commit_idx;
  logic                    w_unused_cfg_bits;

  assign w_commit_idx      = sasa_data[16 +: IDX_W];
  assign w_unused_cfg_bits = ^{sasa_data[30:16], sasa_data[7:5], sasa_data[1:0]};

  // Per-entry hit, with same-cycle writeback forwarded ahead of the SRF
  always_comb begin
    w_cond_zero = '0;
    w_hit       = '0;
    for (int i = 0; i < int'(SASA_ENTRIES); i++) begin
      if (wb_en && (wb_rd == r_rs[i]) && (r_rs[i] != 5'd0))
        w_cond_zero[i] = (wb_data == 32'd0);
      else
        w_cond_zero[i] = r_srf[r_rs[i]];
      w_hit[i] = r_valid[i] && (pc == r_epc[i]) && (r_len[i] != 8'd0) && w_cond_zero[i];
    end
  end

  // Lowest-index hit wins
  always_comb begin
    w_any_hit = |w_hit;
    w_hit_idx = '0;
    for (int i = int'(SASA_ENTRIES) - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = IDX_W'(i);
    end
    w_hit_target = r_epc[w_hit_idx] + (32'(r_len[w_hit_idx]) << 2);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_srf         <= 32'h0000_0001;
      r_valid       <= '0;
      r_stage_pc    <= '0;
      r_cfg_state   <= CFG_IDLE;
      r_skip_state  <= SK_IDLE;
      r_hold        <= '0;
      skipping      <= 1'b0;
      sparce_target <= '0;
    end else begin
      if (wb_en && (wb_rd != 5'd0)) r_srf[wb_rd] <= (wb_data == 32'd0);

      // A commit lands only after a stage; stray commits are dropped
      case (r_cfg_state)
        CFG_IDLE: begin
          if (sasa_wen && (sasa_addr == STAGE_ADDR)) begin
            r_stage_pc  <= {sasa_data[31:2], 2'b00};
            r_cfg_state <= CFG_STAGED;
          end
        end
        CFG_STAGED: begin
          if (sasa_wen && (sasa_addr == STAGE_ADDR)) begin
            r_stage_pc <= {sasa_data[31:2], 2'b00};
          end else if (sasa_wen && (sasa_addr == COMMIT_ADDR)) begin
            r_valid[w_commit_idx] <= sasa_data[31];
            r_epc[w_commit_idx]   <= r_stage_pc;
            r_rs[w_commit_idx]    <= sasa_data[4:0];
            r_len[w_commit_idx]   <= sasa_data[15:8];
            r_cfg_state           <= CFG_IDLE;
          end
        end
        default: r_cfg_state <= CFG_IDLE;
      endcase

      // Redirect is held, target frozen, until fetch acknowledges
      case (r_skip_state)
        SK_IDLE: begin
          if (pc_valid && w_any_hit) begin
            sparce_target <= w_hit_target;
            skipping      <= 1'b1;
            r_skip_state  <= SK_REDIRECT;
          end
        end
        SK_REDIRECT: begin
          if (redirect_ack) begin
            skipping     <= 1'b0;
            r_hold       <= 4'(HOLDOFF);
            r_skip_state <= SK_HOLDOFF;
          end
        end
        SK_HOLDOFF: begin
          if (r_hold <= 4'd1) begin
            r_hold       <= '0;
            r_skip_state <= SK_IDLE;
          end else begin
            r_hold <= r_hold - 4'd1;
          end
        end
        default: r_skip_state <= SK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparce_skip_ctrl.sv
// Directed bench for sparce_skip_ctrl: per-cycle vectors with hand-computed
// expected skipping/sparce_target after each clock edge.
module tb_sparce_skip_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc;
  logic        pc_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        sasa_wen;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic        redirect_ack;
  logic [31:0] sparce_target;
  logic        skipping;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  sparce_skip_ctrl #(
    .SASA_ENTRIES(4),
    .SASA_BASE(32'h0000_2000),
    .HOLDOFF(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .pc(pc),
    .pc_valid(pc_valid),
    .wb_en(wb_en),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .sasa_wen(sasa_wen),
    .sasa_addr(sasa_addr),
    .sasa_data(sasa_data),
    .redirect_ack(redirect_ack),
    .sparce_target(sparce_target),
    .skipping(skipping)
  );

  typedef struct {
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ack;
    logic        exp_skip;
    logic [31:0] exp_tgt;
  } vec_t;

  function automatic vec_t nop(input logic s, input logic [31:0] t);
    vec_t v;
    v.rst = 1'b0; v.pc_valid = 1'b0; v.pc = '0;
    v.wb_en = 1'b0; v.wb_rd = '0; v.wb_data = '0;
    v.wen = 1'b0; v.addr = '0; v.data = '0; v.ack = 1'b0;
    v.exp_skip = s; v.exp_tgt = t;
    return v;
  endfunction

  function automatic vec_t rst_v();
    vec_t v = nop(1'b0, 32'h0);
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t cfg(input logic [31:0] a, input logic [31:0] d,
                               input logic s, input logic [31:0] t);
    vec_t v = nop(s, t);
    v.wen = 1'b1; v.addr = a; v.data = d;
    return v;
  endfunction

  function automatic vec_t wbv(input logic [4:0] rd, input logic [31:0] d,
                               input logic s, input logic [31:0] t);
    vec_t v = nop(s, t);
    v.wb_en = 1'b1; v.wb_rd = rd; v.wb_data = d;
    return v;
  endfunction

  function automatic vec_t pcv(input logic [31:0] p, input logic s, input logic [31:0] t);
    vec_t v = nop(s, t);
    v.pc_valid = 1'b1; v.pc = p;
    return v;
  endfunction

  function automatic vec_t ackv(input logic s, input logic [31:0] t);
    vec_t v = nop(s, t);
    v.ack = 1'b1;
    return v;
  endfunction

  // Drive one cycle, then compare outputs just after the rising edge
  task automatic apply(input vec_t v, input string name);
    RST = v.rst; pc_valid = v.pc_valid; pc = v.pc;
    wb_en = v.wb_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
    sasa_wen = v.wen; sasa_addr = v.addr; sasa_data = v.data;
    redirect_ack = v.ack;
    @(posedge CLK);
    #1;
    n_checks++;
    if (skipping !== v.exp_skip) begin
      n_errors++;
      $display("FAIL %s: skipping=%0b expected %0b", name, skipping, v.exp_skip);
    end
    n_checks++;
    if (sparce_target !== v.exp_tgt) begin
      n_errors++;
      $display("FAIL %s: sparce_target=%h expected %h", name, sparce_target, v.exp_tgt);
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    RST = 1'b1; pc = '0; pc_valid = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    sasa_wen = 1'b0; sasa_addr = '0; sasa_data = '0; redirect_ack = 1'b0;

    // Basic skip, ack and holdoff drain; then the forwarding case
    tbl.push_back(rst_v());
    tbl.push_back(cfg(32'h2000, 32'h0000_0100, 1'b0, 32'h0));
    tbl.push_back(cfg(32'h2004, 32'h8000_0305, 1'b0, 32'h0));
    tbl.push_back(wbv(5'd5, 32'h0, 1'b0, 32'h0));
    tbl.push_back(pcv(32'h100, 1'b1, 32'h10C));
    tbl.push_back(ackv(1'b0, 32'h10C));
    tbl.push_back(nop(1'b0, 32'h10C));
    tbl.push_back(nop(1'b0, 32'h10C));
    tbl.push_back(wbv(5'd5, 32'h7, 1'b0, 32'h10C));
    tbl.push_back(pcv(32'h100, 1'b0, 32'h10C));
    v = pcv(32'h100, 1'b1, 32'h10C);
    v.wb_en = 1'b1; v.wb_rd = 5'd5; v.wb_data = 32'h0;
    tbl.push_back(v);

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Redirect stays stable while SRF and entry 0 change underneath it
    apply(wbv(5'd5, 32'h1, 1'b1, 32'h10C), "t3_wb_x5_one");
    apply(cfg(32'h2000, 32'h0000_0100, 1'b1, 32'h10C), "t3_stage");
    apply(cfg(32'h2004, 32'h8000_0905, 1'b1, 32'h10C), "t3_commit_len9");
    apply(pcv(32'h100, 1'b1, 32'h10C), "t3_pc_a");
    apply(pcv(32'h100, 1'b1, 32'h10C), "t3_pc_b");

    // Holdoff: ack, then pc every cycle; retrigger matched at ack+3
    v = ackv(1'b0, 32'h10C);
    v.wb_en = 1'b1; v.wb_rd = 5'd5; v.wb_data = 32'h0;
    apply(v, "t4_ack");
    apply(pcv(32'h100, 1'b0, 32'h10C), "t4_hold1");
    apply(pcv(32'h100, 1'b0, 32'h10C), "t4_hold2");
    apply(pcv(32'h100, 1'b1, 32'h124), "t4_retrigger");
    apply(ackv(1'b0, 32'h124), "t4_ack2");
    apply(nop(1'b0, 32'h124), "t4_drain1");
    apply(nop(1'b0, 32'h124), "t4_drain2");

    // Commit without stage ignored; lowest index wins; len 0 never hits; restage
    apply(rst_v(), "t5_rst");
    apply(cfg(32'h2000, 32'h0000_0300, 1'b0, 32'h0), "t5_stage300");
    apply(cfg(32'h2004, 32'h0000_0100, 1'b0, 32'h0), "t5_commit_invalid");
    apply(cfg(32'h2004, 32'h8001_0100, 1'b0, 32'h0), "t5_unstaged_commit");
    apply(pcv(32'h300, 1'b0, 32'h0), "t5_pc300_nohit");
    apply(cfg(32'h2000, 32'h0000_0200, 1'b0, 32'h0), "t5_stage200a");
    apply(cfg(32'h2004, 32'h8002_0400, 1'b0, 32'h0), "t5_commit_e2");
    apply(cfg(32'h2000, 32'h0000_0200, 1'b0, 32'h0), "t5_stage200b");
    apply(cfg(32'h2004, 32'h8000_0100, 1'b0, 32'h0), "t5_commit_e0");
    apply(pcv(32'h200, 1'b1, 32'h204), "t5_lowest_idx");
    apply(ackv(1'b0, 32'h204), "t5_ack");
    apply(nop(1'b0, 32'h204), "t5_drain1");
    apply(nop(1'b0, 32'h204), "t5_drain2");
    apply(cfg(32'h2000, 32'h0000_0400, 1'b0, 32'h204), "t5_stage400");
    apply(cfg(32'h2004, 32'h8001_0000, 1'b0, 32'h204), "t5_commit_len0");
    apply(pcv(32'h400, 1'b0, 32'h204), "t5_len0_a");
    apply(pcv(32'h400, 1'b0, 32'h204), "t5_len0_b");
    apply(cfg(32'h2000, 32'h0000_0500, 1'b0, 32'h204), "t5_stage500");
    apply(cfg(32'h2000, 32'h0000_0600, 1'b0, 32'h204), "t5_restage600");
    apply(cfg(32'h2004, 32'h8003_0200, 1'b0, 32'h204), "t5_commit_e3");
    apply(pcv(32'h500, 1'b0, 32'h204), "t5_pc500_nohit");
    apply(pcv(32'h600, 1'b1, 32'h608), "t5_pc600_hit");
    apply(ackv(1'b0, 32'h608), "t5_ack2");
    apply(nop(1'b0, 32'h608), "t5_drain3");
    apply(nop(1'b0, 32'h608), "t5_drain4");

    // Reset during a redirect clears outputs and the table
    apply(cfg(32'h2000, 32'h0000_0100, 1'b0, 32'h608), "t6_stage");
    apply(cfg(32'h2004, 32'h8000_0305, 1'b0, 32'h608), "t6_commit");
    apply(wbv(5'd5, 32'h0, 1'b0, 32'h608), "t6_wb_x5");
    apply(pcv(32'h100, 1'b1, 32'h10C), "t6_hit");
    apply(rst_v(), "t6_rst_mid_redirect");
    apply(wbv(5'd5, 32'h0, 1'b0, 32'h0), "t6_wb_after_rst");
    apply(pcv(32'h100, 1'b0, 32'h0), "t6_pc_cleared_a");
    apply(pcv(32'h100, 1'b0, 32'h0), "t6_pc_cleared_b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
